// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a radix-2^2 SDF FFT pipeline.
// Admits samples over valid/ready, advances the datapath, tags results with
// sop/eop/last on a 1-deep output register, and flushes the pipeline with
// zero samples after the final frame of a burst.
module fft_frame_ctrl #(
  parameter int N_POINTS   = 16,
  parameter int PIPE_LAT   = 20,
  parameter int LOG2N_BITS = $clog2(N_POINTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  dp_en,
  output logic                  dp_zero,
  output logic [LOG2N_BITS-1:0] control_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_last,
  output logic                  err_frame
);

  localparam int FILL_W  = $clog2(PIPE_LAT + 1);
  localparam int FLUSH_W = $clog2(PIPE_LAT);
  localparam logic [LOG2N_BITS-1:0] IDX_MAX   = LOG2N_BITS'(N_POINTS - 1);
  localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(PIPE_LAT);
  localparam logic [FLUSH_W-1:0]    FLUSH_END = FLUSH_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t                  state_q;
  logic [LOG2N_BITS-1:0]   in_cnt_q, in_cnt_d;
  logic [LOG2N_BITS-1:0]   out_cnt_q, out_cnt_d;
  logic [FILL_W-1:0]       fill_cnt_q;
  logic [FLUSH_W-1:0]      flush_cnt_q;
  logic                    out_valid_q;
  logic                    last_frame_q;
  logic                    first_last_q;
  logic                    err_frame_q;

  logic stall;
  logic accept;
  logic produce;
  logic xfer;
  logic final_xfer;

  // A full, unaccepted output register freezes the whole pipeline.
  assign stall = out_valid_q & ~out_ready;

  // Handshake and datapath controls decoded from the current state.
  always_comb begin
    in_ready = 1'b0;
    dp_en    = 1'b0;
    dp_zero  = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        in_ready = ~stall;
        dp_en    = in_valid & ~stall;
      end
      FLUSH: begin
        dp_zero = 1'b1;
        dp_en   = ~stall;
      end
      default: begin
      end
    endcase
  end

  assign accept = in_valid & in_ready;
  // The first result reaches the datapath output only after PIPE_LAT advances
  // beyond the pulse that loaded sample 0, i.e. once fill_cnt has saturated.
  assign produce    = dp_en & (fill_cnt_q == FILL_FULL);
  assign xfer       = out_valid_q & out_ready;
  assign final_xfer = xfer & out_last;

  assign in_cnt_d  = (in_cnt_q == IDX_MAX)  ? '0 : in_cnt_q + LOG2N_BITS'(1);
  assign out_cnt_d = (out_cnt_q == IDX_MAX) ? '0 : out_cnt_q + LOG2N_BITS'(1);

  assign control_bus = in_cnt_q;
  assign out_valid   = out_valid_q;
  assign out_sop     = out_valid_q & (out_cnt_q == '0);
  assign out_eop     = out_valid_q & (out_cnt_q == IDX_MAX);
  assign out_last    = last_frame_q & out_eop;
  assign err_frame   = err_frame_q;

  // Frame FSM, pipeline counters and output tagging state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      fill_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      last_frame_q <= 1'b0;
      first_last_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_q <= RUN;
        end
        RUN: begin
          if (accept && in_last && (in_cnt_q == IDX_MAX)) state_q <= FLUSH;
        end
        FLUSH: begin
          if (dp_en) begin
            if (flush_cnt_q == FLUSH_END) begin
              // Earlier frames may still emit their eop while flushing, so the
              // burst-final tag is armed only once the last flush pulse issues.
              state_q      <= DRAIN;
              flush_cnt_q  <= '0;
              last_frame_q <= 1'b1;
            end else begin
              flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
            end
          end
        end
        default: begin
        end
      endcase

      // Control index keeps stepping through the flush so stage controls stay in sequence.
      if (dp_en) in_cnt_q <= in_cnt_d;
      if (dp_en && (fill_cnt_q != FILL_FULL)) fill_cnt_q <= fill_cnt_q + FILL_W'(1);

      if (produce)   out_valid_q <= 1'b1;
      else if (xfer) out_valid_q <= 1'b0;

      if (xfer) out_cnt_q <= out_cnt_d;

      if (accept && (in_cnt_q == '0)) first_last_q <= in_last;
      if (accept && (in_cnt_q != '0) && in_last && !first_last_q) err_frame_q <= 1'b1;

      if ((state_q == DRAIN) && final_xfer) begin
        state_q      <= IDLE;
        in_cnt_q     <= '0;
        out_cnt_q    <= '0;
        fill_cnt_q   <= '0;
        last_frame_q <= 1'b0;
      end
    end
  end

endmodule
